// File: rtl/freq_count_latch.sv
// freq_count_latch: gated BCD pulse counter with a capture register.
// Counts rising edges of an asynchronous signal while enabled, clears on an
// active-low request, and snapshots the running count for the display stage
// on each rising edge of the latch control. All control inputs come from a
// slower control-clock domain and are resynchronised to clk here.
module freq_count_latch #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sigIn,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  latch,
  output logic [4*DIGITS-1:0]   countOut,
  output logic                  overflowOut,
  output logic                  dataValid
);

  localparam int CW = 4 * DIGITS;

  // Synchroniser chains; the last stage of each chain is the usable signal.
  logic [SYNC_STAGES-1:0] r_sigSync;
  logic [SYNC_STAGES-1:0] r_enSync;
  logic [SYNC_STAGES-1:0] r_clrSync;
  logic [SYNC_STAGES-1:0] r_latSync;

  // Previous values of the synchronised signal and latch for edge detection.
  logic r_sigPrev;
  logic r_latPrev;

  // Running BCD count and sticky overflow flag.
  logic [CW-1:0] r_count;
  logic          r_overflow;

  // Held output registers feeding the display stage.
  logic [CW-1:0] r_countOut;
  logic          r_overflowOut;
  logic          r_dataValid;

  // Synchronised controls and derived strobes.
  logic w_sigS;
  logic w_enS;
  logic w_clrS;
  logic w_latS;
  logic w_sigRise;
  logic w_latRise;
  logic w_countStep;

  // Next BCD value and the all-nines indication that signals a wrap.
  logic [CW-1:0] w_countInc;
  logic          w_allNines;

  assign w_sigS = r_sigSync[SYNC_STAGES-1];
  assign w_enS  = r_enSync[SYNC_STAGES-1];
  assign w_clrS = r_clrSync[SYNC_STAGES-1];
  assign w_latS = r_latSync[SYNC_STAGES-1];

  assign w_sigRise   = w_sigS & ~r_sigPrev;
  assign w_latRise   = w_latS & ~r_latPrev;
  assign w_countStep = w_enS & w_sigRise;

  // Input synchronisers; clear and latch rest at 1 so that leaving reset
  // never looks like a clear request or a latch rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sigSync <= '0;
      r_enSync  <= '0;
      r_clrSync <= '1;
      r_latSync <= '1;
    end else begin
      r_sigSync <= {r_sigSync[SYNC_STAGES-2:0], sigIn};
      r_enSync  <= {r_enSync[SYNC_STAGES-2:0], enable};
      r_clrSync <= {r_clrSync[SYNC_STAGES-2:0], clear};
      r_latSync <= {r_latSync[SYNC_STAGES-2:0], latch};
    end
  end

  // Edge-detect history for the signal under test and the latch control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sigPrev <= 1'b0;
      r_latPrev <= 1'b1;
    end else begin
      r_sigPrev <= w_sigS;
      r_latPrev <= w_latS;
    end
  end

  // Ripple BCD increment: a digit advances only when all lower digits are 9.
  always_comb begin
    logic carry;
    w_countInc = r_count;
    carry      = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (r_count[4*d +: 4] >= 4'd9) begin
          w_countInc[4*d +: 4] = 4'd0;
        end else begin
          w_countInc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
          carry                = 1'b0;
        end
      end
    end
    w_allNines = carry;
  end

  // Counter update: clear wins over counting, and a wrap from all nines
  // sets the sticky overflow flag which only a clear removes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (!w_clrS) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_countStep) begin
      r_count <= w_countInc;
      if (w_allNines) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Capture the pre-update count on a latch rising edge and pulse dataValid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_countOut    <= '0;
      r_overflowOut <= 1'b0;
      r_dataValid   <= 1'b0;
    end else begin
      r_dataValid <= w_latRise;
      if (w_latRise) begin
        r_countOut    <= r_count;
        r_overflowOut <= r_overflow;
      end
    end
  end

  assign countOut    = r_countOut;
  assign overflowOut = r_overflowOut;
  assign dataValid   = r_dataValid;

endmodule

// File: tb/tb_freq_count_latch.sv
// tb_freq_count_latch: directed scenarios plus randomized stimulus for the
// gated BCD counter, checked every cycle against a decimal reference model.
module tb_freq_count_latch;

  localparam int DIGITS = 4;
  localparam int SYNC   = 2;
  localparam int CW     = 4 * DIGITS;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          sigIn  = 1'b0;
  logic          enable = 1'b0;
  logic          clear  = 1'b1;
  logic          latch  = 1'b0;
  logic [CW-1:0] countOut;
  logic          overflowOut;
  logic          dataValid;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain decimal integers.
  int mCount;
  int mOut;
  bit mOvf;
  bit mOutOvf;
  bit mValid;
  bit mRise;
  bit mLatRise;
  bit hS[0:SYNC];
  bit hE[0:SYNC];
  bit hC[0:SYNC];
  bit hL[0:SYNC];

  freq_count_latch #(
    .DIGITS(DIGITS),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sigIn(sigIn),
    .enable(enable),
    .clear(clear),
    .latch(latch),
    .countOut(countOut),
    .overflowOut(overflowOut),
    .dataValid(dataValid)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic int maxValue();
    int r;
    r = 1;
    for (int d = 0; d < DIGITS; d++) r = r * 10;
    return r - 1;
  endfunction

  function automatic logic [CW-1:0] toBcd(input int v);
    logic [CW-1:0] r;
    int rest;
    r    = '0;
    rest = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(rest % 10);
      rest        = rest / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each input is seen SYNC cycles late through a history
  // line; counting and capture follow the decimal rules directly.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCount  = 0;
      mOvf    = 0;
      mOut    = 0;
      mOutOvf = 0;
      mValid  = 0;
      for (int j = 0; j <= SYNC; j++) begin
        hS[j] = 0;
        hE[j] = 0;
        hC[j] = 1;
        hL[j] = 1;
      end
    end else begin
      mRise    = hS[SYNC-1] && !hS[SYNC];
      mLatRise = hL[SYNC-1] && !hL[SYNC];
      mValid   = mLatRise;
      if (mLatRise) begin
        mOut    = mCount;
        mOutOvf = mOvf;
      end
      if (!hC[SYNC-1]) begin
        mCount = 0;
        mOvf   = 0;
      end else if (hE[SYNC-1] && mRise) begin
        if (mCount == maxValue()) begin
          mCount = 0;
          mOvf   = 1;
        end else begin
          mCount = mCount + 1;
        end
      end
      for (int j = SYNC; j > 0; j--) begin
        hS[j] = hS[j-1];
        hE[j] = hE[j-1];
        hC[j] = hC[j-1];
        hL[j] = hL[j-1];
      end
      hS[0] = sigIn;
      hE[0] = enable;
      hC[0] = clear;
      hL[0] = latch;
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model, away from posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("countOut", 32'(countOut), 32'(toBcd(mOut)));
      checkOutput("overflowOut", 32'(overflowOut), 32'(mOutOvf));
      checkOutput("dataValid", 32'(dataValid), 32'(mValid));
      checkOutput("internalCount", 32'(dut.r_count), 32'(toBcd(mCount)));
    end
  end

  // Absolute time limit so a stuck run still ends with a report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input int n, input int half);
    repeat (n) begin
      sigIn = 1'b1;
      repeat (half) @(negedge clk);
      sigIn = 1'b0;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic doClear();
    clear = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Lower then raise latch, expect one dataValid cycle and the literal value.
  task automatic captureAndCheck(input string name, input logic [CW-1:0] expBcd, input logic expOvf);
    int pulses;
    latch = 1'b0;
    repeat (4) @(negedge clk);
    latch  = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (dataValid) pulses++;
    end
    checkOutput({name, " countOut"}, 32'(countOut), 32'(expBcd));
    checkOutput({name, " overflowOut"}, 32'(overflowOut), 32'(expOvf));
    checkOutput({name, " validCycles"}, 32'(pulses), 32'd1);
    checkOutput({name, " modelOut"}, 32'(toBcd(mOut)), 32'(expBcd));
  endtask

  // Directed scenarios followed by a randomized phase.
  initial begin
    int seen;
    int unstable;
    int pulses;
    @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("reset countOut", 32'(countOut), 32'd0);
    checkOutput("reset overflowOut", 32'(overflowOut), 32'd0);
    checkOutput("reset dataValid", 32'(dataValid), 32'd0);
    checkOutput("reset internalCount", 32'(dut.r_count), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] scenario: 37 pulses");
    doClear();
    enable = 1'b1;
    applyStimulus(37, 4);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    captureAndCheck("count37", 16'h0037, 1'b0);

    $display("[TB] scenario: overflow");
    doClear();
    enable = 1'b1;
    applyStimulus(9999, 2);
    captureAndCheck("count9999", 16'h9999, 1'b0);
    applyStimulus(1, 2);
    captureAndCheck("wrap", 16'h0000, 1'b1);
    doClear();
    captureAndCheck("afterClear", 16'h0000, 1'b0);

    $display("[TB] scenario: enable gating");
    doClear();
    enable = 1'b1;
    applyStimulus(5, 2);
    enable = 1'b0;
    applyStimulus(5, 2);
    enable = 1'b1;
    applyStimulus(3, 2);
    captureAndCheck("gated", 16'h0008, 1'b0);

    $display("[TB] scenario: latch with clear");
    latch = 1'b0;
    doClear();
    applyStimulus(12, 2);
    latch = 1'b1;
    clear = 1'b0;
    seen  = 0;
    repeat (8) begin
      @(negedge clk);
      if (dataValid) begin
        seen++;
        checkOutput("latchClear countOut", 32'(countOut), 32'h0012);
        checkOutput("latchClear internalCount", 32'(dut.r_count), 32'd0);
      end
    end
    checkOutput("latchClear validCycles", 32'(seen), 32'd1);
    clear = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] scenario: latch held high");
    unstable = 0;
    pulses   = 0;
    fork
      applyStimulus(25, 2);
      begin
        repeat (100) begin
          @(negedge clk);
          if (dataValid) pulses++;
          if (countOut !== 16'h0012) unstable++;
        end
      end
    join
    checkOutput("heldHigh validCycles", 32'(pulses), 32'd0);
    checkOutput("heldHigh unstableCycles", 32'(unstable), 32'd0);
    checkOutput("heldHigh internalCount", 32'(dut.r_count), 32'h0025);

    $display("[TB] scenario: async reset");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncReset countOut", 32'(countOut), 32'd0);
    checkOutput("asyncReset overflowOut", 32'(overflowOut), 32'd0);
    checkOutput("asyncReset dataValid", 32'(dataValid), 32'd0);
    checkOutput("asyncReset internalCount", 32'(dut.r_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (dataValid) pulses++;
    end
    checkOutput("afterReset validCycles", 32'(pulses), 32'd0);
    checkOutput("afterReset countOut", 32'(countOut), 32'd0);

    $display("[TB] scenario: random");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) sigIn = ~sigIn;
      enable = ($urandom_range(7) != 0);
      clear  = ($urandom_range(31) != 0);
      if ($urandom_range(15) == 0) latch = ~latch;
      if ($urandom_range(599) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
